// File: rtl/i2c_arb_pkg.sv
// Shared widths and FSM encoding for the I2C
// command FIFO requester arbiter.
package i2c_arb_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;
  localparam int GID_W      = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/i2c_req_arbiter_rr_pick.sv
// Round-robin priority picker: first set bit of req
// at or after ptr (wrapping). Ports: req, ptr -> pick, any.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] pick,
  output logic          any
);

  int idx;

  // Scan from farthest to nearest so the
  // candidate closest to ptr is written last.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        pick = IW'(idx);
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing the i2c_master FIFO write port.
// Ports: req_* per requester in, m_* to FIFO, grant_id/busy status.
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  parameter int IDLE_TMO  = 32
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*I2C_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*I2C_DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [I2C_ADDR_W-1:0]         m_addr,
  output logic [I2C_DATA_W-1:0]         m_data,
  output logic                          m_fifo_wr_en,
  input  logic                          m_fifo_full,
  output logic [GID_W-1:0]              grant_id,
  output logic                          busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(IDLE_TMO + 1);

  arb_state_e    state, state_n;
  logic [IW-1:0] owner, owner_n;
  logic [IW-1:0] rr_ptr, rr_ptr_n;
  logic [BW-1:0] beat_cnt, beat_cnt_n;
  logic [TW-1:0] tmo_cnt, tmo_cnt_n;

  logic [IW-1:0] pick;
  logic          any;
  logic          accept;
  logic          rel;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .pick (pick),
    .any  (any)
  );

  assign busy     = (state == GRANT);
  assign grant_id = GID_W'(owner);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      rr_ptr   <= rr_ptr_n;
      beat_cnt <= beat_cnt_n;
      tmo_cnt  <= tmo_cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    owner_n      = owner;
    rr_ptr_n     = rr_ptr;
    beat_cnt_n   = beat_cnt;
    tmo_cnt_n    = tmo_cnt;
    req_ready    = '0;
    m_fifo_wr_en = 1'b0;
    m_addr       = '0;
    m_data       = '0;
    accept       = 1'b0;
    rel          = 1'b0;

    unique case (state)
      IDLE: begin
        if (any) begin
          state_n    = GRANT;
          owner_n    = pick;
          beat_cnt_n = '0;
          tmo_cnt_n  = '0;
        end
      end
      GRANT: begin
        accept = req_valid[owner] & ~m_fifo_full;
        req_ready[owner] = ~m_fifo_full;
        m_fifo_wr_en = accept;
        m_addr = req_addr[int'(owner)*I2C_ADDR_W +: I2C_ADDR_W];
        m_data = req_data[int'(owner)*I2C_DATA_W +: I2C_DATA_W];

        // Only an absent requester ages the grant;
        // a full FIFO with valid high just waits.
        if (accept) begin
          beat_cnt_n = beat_cnt + BW'(1);
          tmo_cnt_n  = '0;
          rel = req_last[owner] |
                (beat_cnt == BW'(MAX_BURST - 1));
        end else if (!req_valid[owner]) begin
          tmo_cnt_n = tmo_cnt + TW'(1);
          rel = (tmo_cnt == TW'(IDLE_TMO - 1));
        end

        if (rel) begin
          state_n    = IDLE;
          beat_cnt_n = '0;
          tmo_cnt_n  = '0;
          rr_ptr_n   = (owner == IW'(NUM_REQ - 1)) ?
                       '0 : owner + IW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: reset, bursts,
// fairness, backpressure, burst/idle limits, mid-burst reset.
module tb_i2c_req_arbiter;

  logic        clk;
  logic        arst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [27:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [6:0]  m_addr;
  logic [7:0]  m_data;
  logic        m_fifo_wr_en;
  logic        m_fifo_full;
  logic [2:0]  grant_id;
  logic        busy;

  int n_tests;
  int n_fail;

  i2c_req_arbiter #(
    .NUM_REQ   (4),
    .MAX_BURST (16),
    .IDLE_TMO  (32)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_last     (req_last),
    .m_addr       (m_addr),
    .m_data       (m_data),
    .m_fifo_wr_en (m_fifo_wr_en),
    .m_fifo_full  (m_fifo_full),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v,
                         input logic [6:0] a,
                         input logic [7:0] d,
                         input logic l);
    req_valid[i]       = v;
    req_addr[7*i +: 7] = a;
    req_data[8*i +: 8] = d;
    req_last[i]        = l;
  endtask

  task automatic do_reset();
    arst        = 1'b1;
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
    req_last    = '0;
    m_fifo_full = 1'b0;
    step();
    arst = 1'b0;
  endtask

  task automatic test_reset();
    arst        = 1'b1;
    m_fifo_full = 1'b0;
    req_valid   = 4'hF;
    req_addr    = 28'h5A5A5A5;
    req_data    = 32'hA5A5A5A5;
    req_last    = 4'hF;
    sample();
    if ({req_ready, m_fifo_wr_en, m_addr, m_data, busy, grant_id}
        !== '0) begin
      $display("FAIL reset_outs got rdy=%b wr=%b a=%h d=%h b=%b g=%0d exp all 0",
               req_ready, m_fifo_wr_en, m_addr, m_data, busy, grant_id);
      n_fail++;
    end
    n_tests++;
    step();
    arst = 1'b0;
    sample();
    if (busy !== 1'b0) begin
      $display("FAIL reset_idle_lat got busy=%b exp 0", busy);
      n_fail++;
    end
    n_tests++;
    step();
    sample();
    if (busy !== 1'b1 || grant_id !== 3'd0) begin
      $display("FAIL reset_first_grant got busy=%b g=%0d exp 1/0",
               busy, grant_id);
      n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_single_burst();
    logic [7:0] dat [3];
    dat[0] = 8'hA1;
    dat[1] = 8'hA2;
    dat[2] = 8'hA3;
    do_reset();
    set_req(1, 1'b1, 7'h50, dat[0], 1'b0);
    for (int b = 0; b < 3; b++) begin
      step();
      set_req(1, 1'b1, 7'h50, dat[b], (b == 2));
      sample();
      if (m_fifo_wr_en !== 1'b1 || m_addr !== 7'h50 ||
          m_data !== dat[b] || req_ready !== 4'b0010 ||
          grant_id !== 3'd1) begin
        $display("FAIL burst_beat%0d got wr=%b a=%h d=%h rdy=%b g=%0d exp 1/50/%h/0010/1",
                 b, m_fifo_wr_en, m_addr, m_data, req_ready,
                 grant_id, dat[b]);
        n_fail++;
      end
      n_tests++;
    end
    step();
    set_req(1, 1'b0, 7'h0, 8'h0, 1'b0);
    sample();
    if (busy !== 1'b0 || m_fifo_wr_en !== 1'b0 ||
        m_addr !== 7'h0) begin
      $display("FAIL burst_release got busy=%b wr=%b a=%h exp 0/0/0",
               busy, m_fifo_wr_en, m_addr);
      n_fail++;
    end
    n_tests++;
    // rr_ptr now 2: with 1 and 2 both asking, 2 wins
    set_req(1, 1'b1, 7'h11, 8'h01, 1'b1);
    set_req(2, 1'b1, 7'h22, 8'h02, 1'b1);
    step();
    sample();
    if (grant_id !== 3'd2 || busy !== 1'b1) begin
      $display("FAIL burst_rr_ptr got g=%0d busy=%b exp 2/1",
               grant_id, busy);
      n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_fairness();
    logic [2:0] exp_g [5];
    exp_g[0] = 3'd0;
    exp_g[1] = 3'd1;
    exp_g[2] = 3'd2;
    exp_g[3] = 3'd3;
    exp_g[4] = 3'd0;
    do_reset();
    for (int i = 0; i < 4; i++)
      set_req(i, 1'b1, 7'(8'h10 + i), 8'(8'hC0 + i), 1'b1);
    for (int n = 0; n < 5; n++) begin
      step();
      sample();
      if (busy !== 1'b1 || grant_id !== exp_g[n] ||
          m_fifo_wr_en !== 1'b1 ||
          m_addr !== 7'(8'h10 + exp_g[n])) begin
        $display("FAIL fair_grant%0d got b=%b g=%0d wr=%b a=%h exp g=%0d",
                 n, busy, grant_id, m_fifo_wr_en, m_addr, exp_g[n]);
        n_fail++;
      end
      n_tests++;
      step();
      sample();
      if (busy !== 1'b0 || m_fifo_wr_en !== 1'b0) begin
        $display("FAIL fair_gap%0d got b=%b wr=%b exp 0/0",
                 n, busy, m_fifo_wr_en);
        n_fail++;
      end
      n_tests++;
    end
  endtask

  task automatic test_backpressure();
    int bad;
    do_reset();
    set_req(2, 1'b1, 7'h33, 8'h10, 1'b0);
    step();
    sample();
    if (m_fifo_wr_en !== 1'b1 || m_data !== 8'h10) begin
      $display("FAIL bp_first got wr=%b d=%h exp 1/10",
               m_fifo_wr_en, m_data);
      n_fail++;
    end
    n_tests++;
    step();
    set_req(2, 1'b1, 7'h33, 8'h11, 1'b0);
    m_fifo_full = 1'b1;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      sample();
      if (m_fifo_wr_en !== 1'b0 || req_ready !== 4'b0000 ||
          busy !== 1'b1 || grant_id !== 3'd2)
        bad++;
      step();
    end
    if (bad !== 0) begin
      $display("FAIL bp_hold got %0d bad cycles exp 0", bad);
      n_fail++;
    end
    n_tests++;
    m_fifo_full = 1'b0;
    sample();
    if (m_fifo_wr_en !== 1'b1 || m_data !== 8'h11 ||
        req_ready !== 4'b0100) begin
      $display("FAIL bp_resume got wr=%b d=%h rdy=%b exp 1/11/0100",
               m_fifo_wr_en, m_data, req_ready);
      n_fail++;
    end
    n_tests++;
    step();
    set_req(2, 1'b1, 7'h33, 8'h12, 1'b1);
    step();
    set_req(2, 1'b0, 7'h0, 8'h0, 1'b0);
    sample();
    if (busy !== 1'b0) begin
      $display("FAIL bp_release got busy=%b exp 0", busy);
      n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_max_burst();
    int wr;
    do_reset();
    set_req(2, 1'b1, 7'h44, 8'h00, 1'b0);
    wr = 0;
    for (int b = 0; b < 16; b++) begin
      step();
      set_req(2, 1'b1, 7'h44, 8'(b), 1'b0);
      sample();
      if (m_fifo_wr_en === 1'b1 && m_data === 8'(b)) wr++;
    end
    if (wr !== 16) begin
      $display("FAIL maxb_beats got %0d writes exp 16", wr);
      n_fail++;
    end
    n_tests++;
    step();
    sample();
    if (busy !== 1'b0 || m_fifo_wr_en !== 1'b0) begin
      $display("FAIL maxb_release got b=%b wr=%b exp 0/0",
               busy, m_fifo_wr_en);
      n_fail++;
    end
    n_tests++;
    step();
    sample();
    if (busy !== 1'b1 || grant_id !== 3'd2 ||
        m_fifo_wr_en !== 1'b1) begin
      $display("FAIL maxb_regrant got b=%b g=%0d wr=%b exp 1/2/1",
               busy, grant_id, m_fifo_wr_en);
      n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_idle_timeout();
    int bad;
    do_reset();
    set_req(0, 1'b1, 7'h0A, 8'h5A, 1'b0);
    step();
    sample();
    if (m_fifo_wr_en !== 1'b1 || grant_id !== 3'd0) begin
      $display("FAIL tmo_grant got wr=%b g=%0d exp 1/0",
               m_fifo_wr_en, grant_id);
      n_fail++;
    end
    n_tests++;
    step();
    set_req(0, 1'b0, 7'h0, 8'h0, 1'b0);
    set_req(1, 1'b1, 7'h0B, 8'h6B, 1'b1);
    bad = 0;
    for (int c = 0; c < 32; c++) begin
      sample();
      if (busy !== 1'b1 || grant_id !== 3'd0 ||
          m_fifo_wr_en !== 1'b0)
        bad++;
      step();
    end
    if (bad !== 0) begin
      $display("FAIL tmo_hold got %0d bad cycles exp 0", bad);
      n_fail++;
    end
    n_tests++;
    sample();
    if (busy !== 1'b0) begin
      $display("FAIL tmo_release got busy=%b exp 0", busy);
      n_fail++;
    end
    n_tests++;
    step();
    sample();
    if (busy !== 1'b1 || grant_id !== 3'd1 ||
        m_fifo_wr_en !== 1'b1 || m_addr !== 7'h0B) begin
      $display("FAIL tmo_next got b=%b g=%0d wr=%b a=%h exp 1/1/1/0b",
               busy, grant_id, m_fifo_wr_en, m_addr);
      n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_req(1, 1'b1, 7'h61, 8'h01, 1'b0);
    step();
    step();
    set_req(1, 1'b1, 7'h61, 8'h02, 1'b0);
    step();
    set_req(1, 1'b1, 7'h61, 8'h03, 1'b0);
    arst = 1'b1;
    sample();
    if (m_fifo_wr_en !== 1'b0 || busy !== 1'b0 ||
        req_ready !== 4'b0000) begin
      $display("FAIL rst_mid got wr=%b b=%b rdy=%b exp 0/0/0000",
               m_fifo_wr_en, busy, req_ready);
      n_fail++;
    end
    n_tests++;
    step();
    arst = 1'b0;
    set_req(0, 1'b1, 7'h60, 8'h00, 1'b1);
    step();
    sample();
    if (busy !== 1'b1 || grant_id !== 3'd0) begin
      $display("FAIL rst_mid_rrptr got b=%b g=%0d exp 1/0",
               busy, grant_id);
      n_fail++;
    end
    n_tests++;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    arst        = 1'b1;
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
    req_last    = '0;
    m_fifo_full = 1'b0;
    test_reset();
    test_single_burst();
    test_fairness();
    test_backpressure();
    test_max_burst();
    test_idle_timeout();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
